// File: rtl/mem_lsu.sv
// Load/store unit: sequences one word/byte load or store onto the data-memory port,
// with read-modify-write for byte stores and a one-cycle done pulse.
module mem_lsu #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ls_valid,
    input  logic        ls_store,
    input  logic        ls_byte,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_ready,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    output logic        ls_misalign,
    output logic        stall,
    output logic [31:0] addr_data,
    output logic [31:0] write_data,
    output logic        we,
    input  logic [31:0] read_data
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    localparam logic [3:0] LastCnt = 4'(RD_LAT - 1);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        store_q;
    logic        byte_q;
    logic        mis_pend_q;
    logic [1:0]  lane_q;
    logic [7:0]  wbyte_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        done_q;
    logic        misalign_q;

    logic [31:0] merged_d;
    logic [7:0]  lane_byte_d;

    always_comb begin
        merged_d                          = read_data;
        merged_d[{lane_q, 3'b000} +: 8]   = wbyte_q;
        lane_byte_d                       = read_data[{lane_q, 3'b000} +: 8];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            store_q    <= 1'b0;
            byte_q     <= 1'b0;
            mis_pend_q <= 1'b0;
            lane_q     <= '0;
            wbyte_q    <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ls_valid) begin
                        store_q    <= ls_store;
                        byte_q     <= ls_byte;
                        lane_q     <= ls_addr[1:0];
                        wbyte_q    <= ls_wdata[7:0];
                        mis_pend_q <= !ls_byte && (ls_addr[1:0] != 2'b00);
                        addr_q     <= {ls_addr[31:2], 2'b00};
                        if (ls_store && !ls_byte) begin
                            we_q    <= 1'b1;
                            wdata_q <= ls_wdata;
                            state_q <= WRITE;
                        end else begin
                            cnt_q   <= '0;
                            state_q <= READ;
                        end
                    end
                end
                READ: begin
                    if (cnt_q == LastCnt) begin
                        cnt_q <= '0;
                        // Byte stores merge the freshly read word; loads finish here.
                        if (store_q) begin
                            we_q    <= 1'b1;
                            wdata_q <= merged_d;
                            state_q <= WRITE;
                        end else begin
                            rdata_q    <= byte_q ? {24'b0, lane_byte_d} : read_data;
                            done_q     <= 1'b1;
                            misalign_q <= mis_pend_q;
                            state_q    <= RESP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                WRITE: begin
                    we_q       <= 1'b0;
                    done_q     <= 1'b1;
                    misalign_q <= mis_pend_q;
                    state_q    <= RESP;
                end
                RESP: begin
                    done_q     <= 1'b0;
                    misalign_q <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ls_ready    = (state_q == IDLE);
    assign stall       = ((state_q == IDLE) && ls_valid) || (state_q == READ) || (state_q == WRITE);
    assign ls_done     = done_q;
    assign ls_rdata    = rdata_q;
    assign ls_misalign = misalign_q;
    assign addr_data   = addr_q;
    assign write_data  = wdata_q;
    assign we          = we_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: two instances (RD_LAT=1 and RD_LAT=3) run the same command stream
// against latency-accurate memory models; a scoreboard checks every ls_done.
module tb_mem_lsu;

    localparam int unsigned LAT0 = 1;
    localparam int unsigned LAT1 = 3;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        ls_valid, ls_store, ls_byte;
    logic [31:0] ls_addr, ls_wdata;

    logic        ready_w [2];
    logic        done_w  [2];
    logic        mis_w   [2];
    logic        stall_w [2];
    logic        we_w    [2];
    logic [31:0] rdata_w [2];
    logic [31:0] addr_w  [2];
    logic [31:0] wd_w    [2];
    logic [31:0] rd_w    [2];

    logic [31:0] ram [2][64];
    logic [31:0] pa1 [2];
    logic        pv1 [2];
    int          wcnt [2];
    logic [31:0] last_waddr [2];

    int   cyc = 0;
    int   acc_edge [2];
    int   dcnt [2];
    logic prev_done [2];
    exp_t q0 [$];
    exp_t q1 [$];

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rd;

    always #5 clk = ~clk;

    mem_lsu #(.RD_LAT(LAT0)) u_lsu0 (
        .clk(clk), .reset(rst), .ls_valid(ls_valid), .ls_store(ls_store), .ls_byte(ls_byte),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_ready(ready_w[0]), .ls_done(done_w[0]),
        .ls_rdata(rdata_w[0]), .ls_misalign(mis_w[0]), .stall(stall_w[0]), .addr_data(addr_w[0]),
        .write_data(wd_w[0]), .we(we_w[0]), .read_data(rd_w[0])
    );

    mem_lsu #(.RD_LAT(LAT1)) u_lsu1 (
        .clk(clk), .reset(rst), .ls_valid(ls_valid), .ls_store(ls_store), .ls_byte(ls_byte),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_ready(ready_w[1]), .ls_done(done_w[1]),
        .ls_rdata(rdata_w[1]), .ls_misalign(mis_w[1]), .stall(stall_w[1]), .addr_data(addr_w[1]),
        .write_data(wd_w[1]), .we(we_w[1]), .read_data(rd_w[1])
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: instance 1 returns data for the address presented two cycles earlier,
    // and only if that address belonged to an active (non-IDLE, non-write) access.
    always @(posedge clk) begin
        if (clr) begin
            for (int g = 0; g < 2; g++) begin
                for (int i = 0; i < 64; i++) ram[g][i] <= '0;
                wcnt[g]       <= 0;
                last_waddr[g] <= '0;
                pa1[g]        <= '0;
                pv1[g]        <= 1'b0;
            end
        end else begin
            for (int g = 0; g < 2; g++) begin
                if (we_w[g]) begin
                    ram[g][addr_w[g][7:2]] <= wd_w[g];
                    wcnt[g]                <= wcnt[g] + 1;
                    last_waddr[g]          <= addr_w[g];
                end
            end
            pa1[0] <= addr_w[1];
            pv1[0] <= !we_w[1] && !ready_w[1];
            pa1[1] <= pa1[0];
            pv1[1] <= pv1[0];
        end
    end

    always_comb begin
        rd_w[0] = ram[0][addr_w[0][7:2]];
        rd_w[1] = pv1[1] ? ram[1][pa1[1][7:2]] : 32'hBAD0BAD0;
    end

    always @(negedge clk) begin
        exp_t e;
        int   lat;
        for (int g = 0; g < 2; g++) begin
            if (rst) begin
                prev_done[g] = 1'b0;
            end else begin
                if (ls_valid && ready_w[g]) acc_edge[g] = cyc + 1;
                if (done_w[g]) begin
                    dcnt[g] = dcnt[g] + 1;
                    checks++;
                    if (prev_done[g]) begin
                        errors++;
                        $display("FAIL done_width inst%0d: ls_done high 2 cycles, required 1", g);
                    end
                    if ((g == 0 && q0.size() == 0) || (g == 1 && q1.size() == 0)) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done inst%0d: ls_done=1, required 0", g);
                    end else begin
                        if (g == 0) e = q0.pop_front();
                        else        e = q1.pop_front();
                        lat = cyc + 1 - acc_edge[g];
                        checks += 3;
                        if (lat !== e.lat) begin
                            errors++;
                            $display("FAIL latency inst%0d: got %0d, required %0d", g, lat, e.lat);
                        end
                        if (mis_w[g] !== e.mis) begin
                            errors++;
                            $display("FAIL misalign inst%0d: got %0b, required %0b", g, mis_w[g], e.mis);
                        end
                        if (rdata_w[g] !== e.rdata) begin
                            errors++;
                            $display("FAIL rdata inst%0d: got %08h, required %08h", g, rdata_w[g], e.rdata);
                        end
                    end
                end else if (mis_w[g]) begin
                    checks++;
                    errors++;
                    $display("FAIL misalign_nodone inst%0d: ls_misalign=1 without ls_done", g);
                end
                prev_done[g] = done_w[g];
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(posedge clk); #1;
        while (!(ready_w[0] && ready_w[1]) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: ls_ready=%0b/%0b, required 1/1", ready_w[0], ready_w[1]);
        end
    endtask

    task automatic issue(input logic st, input logic by, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_mis);
        exp_t e;
        int   d0, d1, n;
        wait_idle();
        ls_store = st; ls_byte = by; ls_addr = a; ls_wdata = wd; ls_valid = 1'b1;
        e.rdata = exp_rd;
        e.mis   = exp_mis;
        e.lat   = (st && !by) ? 2 : (!st ? int'(LAT0) + 1 : int'(LAT0) + 2);
        q0.push_back(e);
        e.lat   = (st && !by) ? 2 : (!st ? int'(LAT1) + 1 : int'(LAT1) + 2);
        q1.push_back(e);
        d0 = dcnt[0];
        d1 = dcnt[1];
        @(posedge clk); #1;
        ls_valid = 1'b0;
        ls_addr  = $urandom;
        ls_wdata = $urandom;
        ls_store = 1'($urandom);
        ls_byte  = 1'($urandom);
        for (int g = 0; g < 2; g++) begin
            checks += 2;
            if (addr_w[g] !== {a[31:2], 2'b00}) begin
                errors++;
                $display("FAIL addr_data inst%0d: got %08h, required %08h", g, addr_w[g], {a[31:2], 2'b00});
            end
            if (stall_w[g] !== 1'b1) begin
                errors++;
                $display("FAIL stall inst%0d: got %0b, required 1", g, stall_w[g]);
            end
        end
        n = 0;
        while ((dcnt[0] == d0 || dcnt[1] == d1) && n < 60) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (n >= 60) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: done counts %0d/%0d, required %0d/%0d", dcnt[0], dcnt[1], d0 + 1, d1 + 1);
        end
        if (!st) last_rd = exp_rd;
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b1;
        ls_valid = 1'b1; ls_store = 1'b1; ls_byte = 1'b0; ls_addr = 32'h20; ls_wdata = 32'h1;
        repeat (5) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            checks += 4;
            if (ready_w[g] !== 1'b1) begin errors++; $display("FAIL reset_ready inst%0d: got %0b, required 1", g, ready_w[g]); end
            if (we_w[g] !== 1'b0) begin errors++; $display("FAIL reset_we inst%0d: got %0b, required 0", g, we_w[g]); end
            if (done_w[g] !== 1'b0) begin errors++; $display("FAIL reset_done inst%0d: got %0b, required 0", g, done_w[g]); end
            if (rdata_w[g] !== 32'h0) begin errors++; $display("FAIL reset_rdata inst%0d: got %08h, required 0", g, rdata_w[g]); end
        end
        ls_valid = 1'b0;
        clr = 1'b0;
        rst = 1'b0;
        last_rd = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (wcnt[g] !== 0) begin errors++; $display("FAIL reset_nowrite inst%0d: writes %0d, required 0", g, wcnt[g]); end
        end
    endtask

    task automatic test_word_store();
        int wb [2];
        for (int g = 0; g < 2; g++) wb[g] = wcnt[g];
        issue(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, last_rd, 1'b0);
        for (int g = 0; g < 2; g++) begin
            checks += 3;
            if (ram[g][4] !== 32'hDEADBEEF) begin errors++; $display("FAIL wstore_ram inst%0d: got %08h, required DEADBEEF", g, ram[g][4]); end
            if (wcnt[g] - wb[g] !== 1) begin errors++; $display("FAIL wstore_count inst%0d: got %0d, required 1", g, wcnt[g] - wb[g]); end
            if (last_waddr[g] !== 32'h10) begin errors++; $display("FAIL wstore_addr inst%0d: got %08h, required 00000010", g, last_waddr[g]); end
        end
    endtask

    task automatic test_word_load();
        issue(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    endtask

    task automatic test_byte_store();
        int wb [2];
        for (int g = 0; g < 2; g++) wb[g] = wcnt[g];
        issue(1'b1, 1'b1, 32'h12, 32'hFFFFFF55, last_rd, 1'b0);
        for (int g = 0; g < 2; g++) begin
            checks += 3;
            if (ram[g][4] !== 32'hDE55BEEF) begin errors++; $display("FAIL bstore_ram inst%0d: got %08h, required DE55BEEF", g, ram[g][4]); end
            if (wcnt[g] - wb[g] !== 1) begin errors++; $display("FAIL bstore_count inst%0d: got %0d, required 1", g, wcnt[g] - wb[g]); end
            if (last_waddr[g] !== 32'h10) begin errors++; $display("FAIL bstore_addr inst%0d: got %08h, required 00000010", g, last_waddr[g]); end
        end
    endtask

    task automatic test_byte_load();
        issue(1'b0, 1'b1, 32'h13, 32'h0, 32'h000000DE, 1'b0);
    endtask

    task automatic test_misaligned();
        issue(1'b0, 1'b0, 32'h11, 32'h0, 32'hDE55BEEF, 1'b1);
    endtask

    task automatic test_store_keeps_rdata();
        issue(1'b1, 1'b0, 32'h20, 32'h12345678, last_rd, 1'b0);
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (ram[g][8] !== 32'h12345678) begin errors++; $display("FAIL store2_ram inst%0d: got %08h, required 12345678", g, ram[g][8]); end
        end
    endtask

    task automatic test_back_to_back();
        issue(1'b0, 1'b0, 32'h20, 32'h0, 32'h12345678, 1'b0);
        issue(1'b0, 1'b1, 32'h21, 32'h0, 32'h00000056, 1'b0);
        issue(1'b0, 1'b1, 32'h10, 32'h0, 32'h000000EF, 1'b0);
        issue(1'b1, 1'b0, 32'h23, 32'hCAFEF00D, last_rd, 1'b1);
        issue(1'b0, 1'b0, 32'h22, 32'h0, 32'hCAFEF00D, 1'b1);
    endtask

    task automatic test_reset_mid();
        int wb [2];
        for (int g = 0; g < 2; g++) wb[g] = wcnt[g];
        wait_idle();
        ls_store = 1'b1; ls_byte = 1'b1; ls_addr = 32'h12; ls_wdata = 32'h000000AA; ls_valid = 1'b1;
        @(posedge clk); #1;
        ls_valid = 1'b0;
        rst = 1'b1;
        #1;
        for (int g = 0; g < 2; g++) begin
            checks += 2;
            if (ready_w[g] !== 1'b1) begin errors++; $display("FAIL rstmid_ready inst%0d: got %0b, required 1", g, ready_w[g]); end
            if (we_w[g] !== 1'b0) begin errors++; $display("FAIL rstmid_we inst%0d: got %0b, required 0", g, we_w[g]); end
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        last_rd = '0;
        repeat (6) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            checks += 3;
            if (wcnt[g] !== wb[g]) begin errors++; $display("FAIL rstmid_nowrite inst%0d: writes %0d, required %0d", g, wcnt[g], wb[g]); end
            if (ram[g][4] !== 32'hDE55BEEF) begin errors++; $display("FAIL rstmid_ram inst%0d: got %08h, required DE55BEEF", g, ram[g][4]); end
            if (rdata_w[g] !== 32'h0) begin errors++; $display("FAIL rstmid_rdata inst%0d: got %08h, required 0", g, rdata_w[g]); end
        end
        issue(1'b0, 1'b0, 32'h10, 32'h0, 32'hDE55BEEF, 1'b0);
    endtask

    initial begin
        for (int g = 0; g < 2; g++) begin
            dcnt[g]      = 0;
            acc_edge[g]  = 0;
            prev_done[g] = 1'b0;
        end
        test_reset();
        test_word_store();
        test_word_load();
        test_byte_store();
        test_byte_load();
        test_misaligned();
        test_store_keeps_rdata();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            checks++;
            if ((g == 0 && q0.size() != 0) || (g == 1 && q1.size() != 0)) begin
                errors++;
                $display("FAIL pending_done inst%0d: expected completions still outstanding", g);
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
